// File: rtl/board_port_arbiter.sv
// board_port_arbiter: grants the shared single-port playfield RAM to one of the
// two block-drop engines at a time. Ownership is round-robin with a hold limit,
// and the board is only accessed while the game FSM reports "dropping".
module board_port_arbiter #(
   parameter int unsigned ADDR_W   = 9,
   parameter int unsigned DATA_W   = 4,
   parameter int unsigned MAX_HOLD = 16
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic [2:0]        game_state,
   input  logic              req0,
   input  logic              req1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic              we0,
   input  logic              we1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   input  logic              last0,
   input  logic              last1,
   output logic              grant0,
   output logic              grant1,
   output logic [DATA_W-1:0] rdata,
   output logic              rvalid0,
   output logic              rvalid1,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   localparam int unsigned HOLD_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

   typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_e;

   state_e            state_q, state_d;
   logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
   logic              last_served_q, last_served_d;
   logic              rvalid0_q, rvalid0_d;
   logic              rvalid1_q, rvalid1_d;

   logic enable;
   logic beat0, beat1;

   assign enable = (game_state == 3'b010);
   assign beat0  = (state_q == OWN0) && req0;
   assign beat1  = (state_q == OWN1) && req1;

   // State, hold counter, fairness pointer and read-return registers
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q       <= IDLE;
         hold_cnt_q    <= '0;
         last_served_q <= 1'b1;
         rvalid0_q     <= 1'b0;
         rvalid1_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         hold_cnt_q    <= hold_cnt_d;
         last_served_q <= last_served_d;
         rvalid0_q     <= rvalid0_d;
         rvalid1_q     <= rvalid1_d;
      end
   end

   // Next-state: arbitration in IDLE, exit on last beat, hold limit or disable
   always_comb begin
      state_d       = state_q;
      hold_cnt_d    = '0;
      last_served_d = last_served_q;
      rvalid0_d     = beat0 && !we0;
      rvalid1_d     = beat1 && !we1;
      unique case (state_q)
         IDLE: begin
            if (enable) begin
               if (req0 && req1)
                  state_d = last_served_q ? OWN0 : OWN1;
               else if (req0)
                  state_d = OWN0;
               else if (req1)
                  state_d = OWN1;
            end
         end
         OWN0: begin
            // All exit causes merge into one exit, so last_served updates once
            if (!enable || (beat0 && last0) || (hold_cnt_q == HOLD_LAST)) begin
               state_d       = IDLE;
               last_served_d = 1'b0;
            end else begin
               hold_cnt_d = hold_cnt_q + 1'b1;
            end
         end
         OWN1: begin
            if (!enable || (beat1 && last1) || (hold_cnt_q == HOLD_LAST)) begin
               state_d       = IDLE;
               last_served_d = 1'b1;
            end else begin
               hold_cnt_d = hold_cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs: grants from state, RAM port muxed from the current owner
   always_comb begin
      grant0    = (state_q == OWN0);
      grant1    = (state_q == OWN1);
      busy      = (state_q != IDLE);
      mem_addr  = '0;
      mem_we    = 1'b0;
      mem_wdata = '0;
      if (state_q == OWN0) begin
         mem_addr  = addr0;
         mem_we    = beat0 && we0;
         mem_wdata = wdata0;
      end else if (state_q == OWN1) begin
         mem_addr  = addr1;
         mem_we    = beat1 && we1;
         mem_wdata = wdata1;
      end
      rvalid0 = rvalid0_q;
      rvalid1 = rvalid1_q;
      rdata   = (rvalid0_q || rvalid1_q) ? mem_rdata : '0;
   end

endmodule
